tcu_rsp_merge: RTL and testbench
================================

Name: tcu_rsp_merge

Overview:
- Return-path merger for one TCU block: collects result beats from PE_COUNT processing elements (FP, INT, ...) and merges them into the single per-block result stream that feeds the gather unit.
- Is the response-direction counterpart of the block's PE request steering: arbitrates round-robin across PEs and keeps each multi-beat result packet (sop..eop) contiguous.
- Decouples PE-side ready from downstream ready with a 2-entry output FIFO.

Parameters:
- PE_COUNT, 2, number of PE result sources (>=1).
- DATA_WIDTH, 256, width of one result beat (wid, tmask, PC, rd, pid and data, packed by the caller).
- SEL_W, max(1,clog2(PE_COUNT)), width of the source-index field (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  PE_COUNT  per-PE beat valid.
- in_data  in  PE_COUNT*DATA_WIDTH  per-PE beat payload; PE i occupies slice i.
- in_sop  in  PE_COUNT  per-PE first-beat-of-packet flag.
- in_eop  in  PE_COUNT  per-PE last-beat-of-packet flag.
- in_ready  out  PE_COUNT  per-PE beat accepted this cycle.
- out_valid  out  1  merged beat valid.
- out_data  out  DATA_WIDTH  merged payload.
- out_sop  out  1  merged first-beat flag.
- out_eop  out  1  merged last-beat flag.
- out_sel  out  SEL_W  index of the PE that produced the beat.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO is emptied; out_valid=0; out_data, out_sop, out_eop and out_sel are 0.
  - in_ready=0 while reset is held.
  - rr_ptr=0; lock=0.
- Handshake:
  - Both sides use valid/ready; a beat transfers when valid&&ready.
  - A PE must hold valid and payload stable until it is accepted (assertion).
  - out_valid never depends on in_valid combinationally.
  - in_ready never depends on out_ready combinationally.
- FIFO:
  - 2 entries, each holding {data, sop, eop, sel}.
  - space = (count<2).
  - push = the accepted input beat; pop = out_valid&&out_ready.
  - Simultaneous push and pop leaves count unchanged.
  - out_* always reflects the FIFO head.
- Latency: a beat accepted in cycle N appears on out_valid in cycle N+1 at the earliest.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Arbitration state UNLOCKED:
  - Candidates are all PEs with in_valid=1.
  - grant is the first candidate found scanning upward from rr_ptr, wrapping modulo PE_COUNT.
  - in_ready[grant]=space; all other in_ready bits are 0.
  - Accepted beat with eop=1: rr_ptr <- grant+1 (mod PE_COUNT); state stays UNLOCKED.
  - Accepted beat with eop=0: lock_sel <- grant; go to LOCKED.
- Arbitration state LOCKED:
  - Only lock_sel is eligible: in_ready[lock_sel]=space; all other bits are 0, even if those PEs are valid.
  - Accepted beat with eop=1: rr_ptr <- lock_sel+1; go to UNLOCKED.
  - If lock_sel drops valid mid-packet, the merger idles and waits; no other PE is granted.
- Protocol assertions (fatal in simulation):
  - A beat with sop=1 accepted while LOCKED.
  - A beat with sop=0 accepted while UNLOCKED.
  - In both cases the hardware still forwards the beat and follows the eop transition rules above.
- PE_COUNT=1: grant is always 0; out_sel is always 0; the lock logic still tracks eop.
- Reset asserted mid-packet:
  - Lock and FIFO are cleared immediately, so partial packets are dropped.
  - The PEs are reset by the same signal, so no orphan beats remain.
- Beats from one PE leave in the order they were accepted. Ordering across different PEs is not guaranteed.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with in_valid=2'b11 -> in_ready=0 and out_valid=0 throughout. Release with in_valid=0 -> out_valid stays 0 for 10 cycles.
- Fair single-beat: both PEs present continuous sop=eop=1 beats (PE0 data 0xA0,0xA1,...; PE1 data 0xB0,...) with out_ready=1 -> out_sel sequence 0,1,0,1,...; out_data A0,B0,A1,B1; first out_valid one cycle after the first accept; one beat per cycle.
- Packet lock: PE0 sends a 3-beat packet (sop on beat 0, eop on beat 2) while PE1 holds a single beat -> output is PE0 beats 0,1,2 back-to-back, then PE1's beat; rr_ptr returns to 0 afterwards.
- Lock stall: PE1 starts a 2-beat packet, then drops valid for 4 cycles while PE0 is valid -> in_ready[0] stays 0 for those 4 cycles; when PE1 resumes, its eop beat follows directly, then PE0's beat.
- Backpressure: out_ready=0 for 5 cycles while both PEs stream -> exactly 2 beats are accepted, then in_ready=0. Raise out_ready -> the 2 held beats drain in order with no loss or duplication, and streaming resumes.
- Async reset mid-packet: assert reset after beat 1 of a 3-beat PE0 packet -> out_valid=0 in the same cycle. After release, a fresh single beat from PE1 is granted immediately (no stale lock).

Source files
------------

// File: rtl/tcu_rsp_merge.sv
// Return-path merger: round-robin arbitration across PE result streams with
// packet locking (sop..eop stays contiguous), buffered by a 2-entry output FIFO.
module tcu_rsp_merge #(
  parameter int PE_COUNT   = 2,
  parameter int DATA_WIDTH = 256,
  parameter int SEL_W      = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PE_COUNT-1:0]            in_valid,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] in_data,
  input  logic [PE_COUNT-1:0]            in_sop,
  input  logic [PE_COUNT-1:0]            in_eop,
  output logic [PE_COUNT-1:0]            in_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_sop,
  output logic                           out_eop,
  output logic [SEL_W-1:0]               out_sel,
  input  logic                           out_ready
);

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [SEL_W-1:0]      sel;
  } entry_t;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]   lock_sel_q, lock_sel_d;
  entry_t             fifo_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q;

  logic [DATA_WIDTH-1:0] pe_data [PE_COUNT];
  logic [SEL_W-1:0]   grant;
  logic               found;
  int                 scan_idx;
  logic               space, push, pop;
  entry_t             in_beat, head;

  for (genvar g = 0; g < PE_COUNT; g++) begin : g_unpack
    assign pe_data[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign space = (count_q != 2'd2);
  assign head  = fifo_q[rd_ptr_q];
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head.data;
  assign out_sop   = head.sop;
  assign out_eop   = head.eop;
  assign out_sel   = head.sel;
  assign pop       = out_valid && out_ready;

  // While locked only the packet owner may be granted; otherwise scan upward from rr_ptr.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    scan_idx = 0;
    if (state_q == LOCKED) begin
      grant = lock_sel_q;
      found = in_valid[lock_sel_q];
    end else begin
      for (int k = 0; k < PE_COUNT; k++) begin
        scan_idx = int'(rr_ptr_q) + k;
        if (scan_idx >= PE_COUNT) scan_idx = scan_idx - PE_COUNT;
        if (!found && in_valid[SEL_W'(scan_idx)]) begin
          grant = SEL_W'(scan_idx);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (reset && space) begin
      if (state_q == LOCKED) in_ready[lock_sel_q] = 1'b1;
      else if (found)        in_ready[grant]      = 1'b1;
    end
  end

  assign push         = |(in_ready & in_valid);
  assign in_beat.data = pe_data[grant];
  assign in_beat.sop  = in_sop[grant];
  assign in_beat.eop  = in_eop[grant];
  assign in_beat.sel  = grant;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_sel_d = lock_sel_q;
    if (push) begin
      if (in_beat.eop) begin
        rr_ptr_d = (grant == SEL_W'(PE_COUNT - 1)) ? '0 : grant + 1'b1;
        state_d  = UNLOCKED;
      end else begin
        lock_sel_d = grant;
        state_d    = LOCKED;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= UNLOCKED;
      rr_ptr_q   <= '0;
      lock_sel_q <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_sel_q <= lock_sel_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= in_beat;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifndef SYNTHESIS
  // Framing violations are still forwarded by the hardware, but stop simulation.
  assert property (@(posedge clk) disable iff (!reset)
    (push && state_q == LOCKED) |-> !in_beat.sop)
    else $fatal(1, "tcu_rsp_merge: sop accepted while locked");

  assert property (@(posedge clk) disable iff (!reset)
    (push && state_q == UNLOCKED) |-> in_beat.sop)
    else $fatal(1, "tcu_rsp_merge: non-sop beat accepted while unlocked");

  for (genvar g = 0; g < PE_COUNT; g++) begin : g_hold_chk
    assert property (@(posedge clk) disable iff (!reset)
      (in_valid[g] && !in_ready[g]) |=>
        (in_valid[g] && $stable(in_data[g*DATA_WIDTH +: DATA_WIDTH])))
      else $fatal(1, "tcu_rsp_merge: PE dropped or changed an unaccepted beat");
  end
`endif

endmodule

// File: tb/tb_tcu_rsp_merge.sv
// Bench for tcu_rsp_merge: per-PE packet queues drive the DUT; a queue-based
// reference (lock owner, round-robin pointer, 2-deep output queue) predicts every cycle.
module tb_tcu_rsp_merge;

  localparam int PE = 2;
  localparam int DW = 256;
  localparam int SW = 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
    logic [SW-1:0] sel;
  } beat_t;

  logic          clk, reset, out_valid, out_sop, out_eop, out_ready;
  logic [PE-1:0] in_valid, in_sop, in_eop, in_ready;
  logic [PE*DW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_sel;

  int total = 0;
  int bad   = 0;

  beat_t srcq [PE][$];
  bit    pause [PE];
  bit    held [PE];
  beat_t mq [$];
  bit    m_locked;
  int    m_owner, m_rr;
  logic [PE-1:0] exp_ready;
  logic  exp_valid;
  beat_t exp_head;
  beat_t got [$];

  tcu_rsp_merge #(.PE_COUNT(PE), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < PE; i++) begin
      srcq[i].delete();
      pause[i] = 1'b0;
      held[i]  = 1'b0;
    end
    mq.delete();
    got.delete();
    m_locked = 1'b0;
    m_owner  = 0;
    m_rr     = 0;
  endtask

  task automatic push_beat(input int pe, input logic [DW-1:0] d, input logic s, input logic e);
    beat_t b;
    b.d = d; b.s = s; b.e = e; b.sel = '0;
    srcq[pe].push_back(b);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Present source heads, then predict ready/valid/head from the reference state.
  task automatic drive();
    bit hit;
    for (int i = 0; i < PE; i++) begin
      in_valid[i] = held[i] || (srcq[i].size() > 0 && !pause[i]);
      if (srcq[i].size() > 0) begin
        in_data[i*DW +: DW] = srcq[i][0].d;
        in_sop[i] = srcq[i][0].s;
        in_eop[i] = srcq[i][0].e;
      end
    end
    exp_ready = '0;
    hit = 1'b0;
    if (mq.size() < 2) begin
      if (m_locked) exp_ready[m_owner] = 1'b1;
      else for (int k = 0; k < PE; k++) begin
        int p;
        p = (m_rr + k) % PE;
        if (!hit && in_valid[p]) begin
          exp_ready[p] = 1'b1;
          hit = 1'b1;
        end
      end
    end
    exp_valid = (mq.size() > 0);
    if (exp_valid) exp_head = mq[0];
    #1;
  endtask

  task automatic advance();
    beat_t b;
    bit acc;
    int g;
    acc = 1'b0;
    g = 0;
    for (int i = 0; i < PE; i++)
      if (in_valid[i] && exp_ready[i]) begin acc = 1'b1; g = i; end
    if (out_ready && mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      b = srcq[g].pop_front();
      b.sel = SW'(g);
      mq.push_back(b);
      if (b.e) begin m_locked = 1'b0; m_rr = (g + 1) % PE; end
      else begin m_locked = 1'b1; m_owner = g; end
    end
    for (int i = 0; i < PE; i++) held[i] = in_valid[i] && !(acc && g == i);
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid = 2'b11; in_sop = 2'b11; in_eop = 2'b11; in_data = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++;
      if (in_ready !== 2'b00 || out_valid !== 1'b0) begin
        bad++; $display("FAIL reset_hold: ready=%b valid=%b, want 00/0", in_ready, out_valid);
      end
    end
    in_valid = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 2'b00) begin
        bad++; $display("FAIL reset_idle: valid=%b ready=%b, want 0/00", out_valid, in_ready);
      end
      advance();
    end
  endtask

  task automatic test_fair();
    int fa, fv, lv;
    fa = -1; fv = -1; lv = -1;
    got.delete();
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      push_beat(0, DW'(32'hA0 + j), 1'b1, 1'b1);
      push_beat(1, DW'(32'hB0 + j), 1'b1, 1'b1);
    end
    for (int c = 0; c < 40 && got.size() < 16; c++) begin
      drive();
      total++;
      if ({in_ready, out_valid} !== {exp_ready, exp_valid}) begin
        bad++; $display("FAIL fair_hs: ready/valid=%b/%b want %b/%b", in_ready, out_valid, exp_ready, exp_valid);
      end
      if (exp_valid) begin
        total++;
        if ({out_data, out_sop, out_eop, out_sel} !== {exp_head.d, exp_head.s, exp_head.e, exp_head.sel}) begin
          bad++; $display("FAIL fair_head: got %h sel=%0d want %h sel=%0d", out_data, out_sel, exp_head.d, exp_head.sel);
        end
      end
      if (fa < 0 && (in_ready & in_valid) != 0) fa = c;
      if (fv < 0 && out_valid) fv = c;
      if (out_valid && out_ready) begin
        got.push_back('{out_data, out_sop, out_eop, out_sel});
        lv = c;
      end
      advance();
    end
    total++;
    if (got.size() != 16) begin
      bad++; $display("FAIL fair_count: got %0d beats want 16", got.size());
    end
    for (int j = 0; j < got.size(); j++) begin
      total++;
      if (got[j].sel !== SW'(j % 2) || got[j].d !== DW'((j % 2 ? 32'hB0 : 32'hA0) + j / 2)) begin
        bad++; $display("FAIL fair_order[%0d]: got sel=%0d data=%h", j, got[j].sel, got[j].d);
      end
    end
    total++;
    if (fv != fa + 1) begin
      bad++; $display("FAIL fair_latency: first valid cycle %0d want %0d", fv, fa + 1);
    end
    total++;
    if (lv - fv != 15) begin
      bad++; $display("FAIL fair_rate: 16 beats spanned %0d cycles want 16", lv - fv + 1);
    end
  endtask

  task automatic test_packet_lock();
    got.delete();
    out_ready = 1'b1;
    push_beat(0, DW'(32'h500), 1'b1, 1'b0);
    push_beat(0, DW'(32'h501), 1'b0, 1'b0);
    push_beat(0, DW'(32'h502), 1'b0, 1'b1);
    push_beat(1, DW'(32'h600), 1'b1, 1'b1);
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      drive();
      total++;
      if ({in_ready, out_valid} !== {exp_ready, exp_valid}) begin
        bad++; $display("FAIL lock_hs: ready/valid=%b/%b want %b/%b", in_ready, out_valid, exp_ready, exp_valid);
      end
      if (out_valid && out_ready) got.push_back('{out_data, out_sop, out_eop, out_sel});
      advance();
    end
    for (int j = 0; j < 4; j++) begin
      logic [DW-1:0] wd;
      wd = (j < 3) ? DW'(32'h500 + j) : DW'(32'h600);
      total++;
      if (j >= got.size() || got[j].d !== wd || got[j].sel !== SW'(j == 3)) begin
        bad++; $display("FAIL lock_order[%0d]: beat missing or wrong, want data %h", j, wd);
      end
    end
    push_beat(0, DW'(32'h510), 1'b1, 1'b1);
    push_beat(1, DW'(32'h610), 1'b1, 1'b1);
    drive();
    total++;
    if (in_ready !== 2'b01) begin
      bad++; $display("FAIL lock_rr_back: ready=%b want 01", in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      advance();
      drive();
      total++;
      if ({in_ready, out_valid} !== {exp_ready, exp_valid}) begin
        bad++; $display("FAIL lock_drain: ready/valid=%b/%b want %b/%b", in_ready, out_valid, exp_ready, exp_valid);
      end
    end
    advance();
  endtask

  task automatic test_lock_stall();
    got.delete();
    out_ready = 1'b1;
    push_beat(1, DW'(32'h700), 1'b1, 1'b0);
    push_beat(1, DW'(32'h701), 1'b0, 1'b1);
    drive();
    total++;
    if (in_ready !== 2'b10) begin
      bad++; $display("FAIL stall_start: ready=%b want 10", in_ready);
    end
    advance();
    push_beat(0, DW'(32'h800), 1'b1, 1'b1);
    pause[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive();
      total++;
      if (in_ready[0] !== 1'b0 || in_valid[0] !== 1'b1 || {in_ready, out_valid} !== {exp_ready, exp_valid}) begin
        bad++; $display("FAIL stall_hold[%0d]: ready=%b valid=%b want %b/%b", c, in_ready, out_valid, exp_ready, exp_valid);
      end
      if (out_valid && out_ready) got.push_back('{out_data, out_sop, out_eop, out_sel});
      advance();
    end
    pause[1] = 1'b0;
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      drive();
      total++;
      if ({in_ready, out_valid} !== {exp_ready, exp_valid}) begin
        bad++; $display("FAIL stall_resume: ready/valid=%b/%b want %b/%b", in_ready, out_valid, exp_ready, exp_valid);
      end
      if (out_valid && out_ready) got.push_back('{out_data, out_sop, out_eop, out_sel});
      advance();
    end
    total++;
    if (got.size() != 3 || got[0].d !== DW'(32'h700) || got[1].d !== DW'(32'h701) || got[2].d !== DW'(32'h800)
        || got[1].sel !== 1'b1 || got[2].sel !== 1'b0) begin
      bad++; $display("FAIL stall_order: %0d beats, want 700,701 (PE1) then 800 (PE0)", got.size());
    end
  endtask

  task automatic test_backpressure();
    int acc, n0, n1;
    acc = 0; n0 = 0; n1 = 0;
    got.delete();
    for (int j = 0; j < 6; j++) begin
      push_beat(0, DW'(32'h100 + j), 1'b1, 1'b1);
      push_beat(1, DW'(32'h200 + j), 1'b1, 1'b1);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive();
      total++;
      if ({in_ready, out_valid} !== {exp_ready, exp_valid}) begin
        bad++; $display("FAIL bp_hs: ready/valid=%b/%b want %b/%b", in_ready, out_valid, exp_ready, exp_valid);
      end
      if (c >= 2) begin
        total++;
        if (in_ready !== 2'b00) begin
          bad++; $display("FAIL bp_full[%0d]: ready=%b want 00", c, in_ready);
        end
      end
      acc += $countones(in_ready & in_valid);
      advance();
    end
    total++;
    if (acc != 2) begin
      bad++; $display("FAIL bp_accepts: %0d accepted want 2", acc);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got.size() < 12; c++) begin
      drive();
      total++;
      if ({in_ready, out_valid} !== {exp_ready, exp_valid}) begin
        bad++; $display("FAIL bp_drain_hs: ready/valid=%b/%b want %b/%b", in_ready, out_valid, exp_ready, exp_valid);
      end
      if (exp_valid) begin
        total++;
        if ({out_data, out_sel} !== {exp_head.d, exp_head.sel}) begin
          bad++; $display("FAIL bp_head: got %h want %h", out_data, exp_head.d);
        end
      end
      if (out_valid && out_ready) got.push_back('{out_data, out_sop, out_eop, out_sel});
      advance();
    end
    for (int j = 0; j < got.size(); j++) begin
      logic [DW-1:0] wd;
      wd = (got[j].sel == 1'b0) ? DW'(32'h100 + n0) : DW'(32'h200 + n1);
      if (got[j].sel == 1'b0) n0++; else n1++;
      total++;
      if (got[j].d !== wd) begin
        bad++; $display("FAIL bp_order[%0d]: got %h want %h", j, got[j].d, wd);
      end
    end
    total++;
    if (n0 != 6 || n1 != 6) begin
      bad++; $display("FAIL bp_total: PE0 %0d PE1 %0d beats, want 6/6", n0, n1);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    acc = 0;
    out_ready = 1'b1;
    push_beat(0, DW'(32'h300), 1'b1, 1'b0);
    push_beat(0, DW'(32'h301), 1'b0, 1'b0);
    push_beat(0, DW'(32'h302), 1'b0, 1'b1);
    for (int c = 0; c < 10 && acc < 2; c++) begin
      drive();
      acc += $countones(in_ready & in_valid);
      advance();
    end
    total++;
    if (acc != 2) begin
      bad++; $display("FAIL rmid_setup: %0d beats accepted want 2", acc);
    end
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 2'b00) begin
      bad++; $display("FAIL rmid_clear: valid=%b ready=%b want 0/00", out_valid, in_ready);
    end
    in_valid = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push_beat(1, DW'(32'h400), 1'b1, 1'b1);
    drive();
    total++;
    if (in_ready !== 2'b10 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_fresh: ready=%b valid=%b want 10/0", in_ready, out_valid);
    end
    advance();
    drive();
    total++;
    if (out_valid !== 1'b1 || out_data !== DW'(32'h400) || out_sel !== 1'b1) begin
      bad++; $display("FAIL rmid_out: valid=%b data=%h sel=%0d want 1/400/1", out_valid, out_data, out_sel);
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < PE; i++) begin
        if (srcq[i].size() < 2) begin
          int n;
          n = $urandom_range(1, 3);
          for (int j = 0; j < n; j++) push_beat(i, rnd_data(), j == 0, j == n - 1);
        end
        pause[i] = ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      drive();
      total++;
      if ({in_ready, out_valid} !== {exp_ready, exp_valid}) begin
        bad++; $display("FAIL rnd_hs[%0d]: ready/valid=%b/%b want %b/%b", c, in_ready, out_valid, exp_ready, exp_valid);
      end
      if (exp_valid) begin
        total++;
        if ({out_data, out_sop, out_eop, out_sel} !== {exp_head.d, exp_head.s, exp_head.e, exp_head.sel}) begin
          bad++; $display("FAIL rnd_head[%0d]: got %h %b%b sel=%0d want %h %b%b sel=%0d", c, out_data, out_sop, out_eop,
                          out_sel, exp_head.d, exp_head.s, exp_head.e, exp_head.sel);
        end
      end
      advance();
    end
    for (int i = 0; i < PE; i++) pause[i] = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 80 && (mq.size() > 0 || srcq[0].size() > 0 || srcq[1].size() > 0); c++) begin
      drive();
      total++;
      if ({in_ready, out_valid} !== {exp_ready, exp_valid}) begin
        bad++; $display("FAIL rnd_drain: ready/valid=%b/%b want %b/%b", in_ready, out_valid, exp_ready, exp_valid);
      end
      advance();
    end
    total++;
    if (mq.size() != 0 || srcq[0].size() != 0 || srcq[1].size() != 0) begin
      bad++; $display("FAIL rnd_timeout: %0d beats still pending", mq.size() + srcq[0].size() + srcq[1].size());
    end
  endtask

  initial begin
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0;
    test_reset();
    test_fair();
    test_packet_lock();
    test_lock_stall();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
